u_enc: RTL and testbench



---
 rtl/u_enc_pkg.sv | 21 ++
 rtl/u_enc_cell.sv | 24 ++
 rtl/u_enc.sv | 147 ++++++++++++++
 tb/tb_u_enc.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/u_enc_pkg.sv
// -----------------------------------------------------------------------------
// u_pkg: shared definitions for the unary (thermometer) code generator.
//
// Contents:
//   u_cnt_w(w)  - width of a binary count able to express 0..w inclusive.
//   U_Q_DEPTH   - depth of the output queue in u_enc.
//
// Queue entry layout is {err, x}: the error flag sits above the P_W-bit code
// word. Packages cannot carry parameterised types, so u_enc declares its own
// entry_t struct in that field order.
// -----------------------------------------------------------------------------
package u_pkg;

  // The queue uses 1-bit pointers and a 2-bit occupancy, so this stays at 2.
  localparam int U_Q_DEPTH = 2;

  function automatic int u_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/u_enc_cell.sv
// -----------------------------------------------------------------------------
// u_enc_cell: one bit slice of the thermometer encoder.
//
// Ports:
//   n_eff  in   P_CNT_W  clamped count of ones (0..P_W)
//   cmpl   in   1        invert this bit (complemented code requested)
//   x      out  1        code bit at position P_K
//
// Ones fill from the LSB, so bit P_K is set when P_K < n_eff.
// -----------------------------------------------------------------------------
module u_enc_cell #(
  parameter int P_K     = 0,
  parameter int P_CNT_W = 1
) (
  input  logic [P_CNT_W-1:0] n_eff,
  input  logic               cmpl,
  output logic               x
);

  localparam logic [P_CNT_W-1:0] K_V = P_CNT_W'(P_K);

  assign x = (K_V < n_eff) ^ cmpl;

endmodule

// File: rtl/u_enc.sv
// -----------------------------------------------------------------------------
// u_enc: streaming unary (thermometer) code generator with a 2-entry queue.
//
// Ports:
//   clk        in   1        clock, rising edge
//   arst       in   1        asynchronous reset, active-high
//   i_in_vld   in   1        input word valid
//   i_in_n     in   CNT_W    requested count of ones
//   i_in_cmpl  in   1        request complemented code
//   o_in_rdy   out  1        queue can accept an input word
//   o_out_vld  out  1        head of queue valid
//   o_out_x    out  P_W      emitted code word (head of queue)
//   o_out_err  out  1        head word was saturated or had its complement refused
//   i_out_rdy  in   1        consumer accepts the head
//   i_err_clr  in   1        synchronous clear of the error counter
//   o_err_cnt  out  ERR_W    saturating count of accepted erroneous inputs
//
// Words are encoded combinationally at the input and stored already encoded,
// so the outputs come straight from the queue registers.
// -----------------------------------------------------------------------------
module u_enc
  import u_pkg::*;
#(
  parameter int P_W                   = 16,
  parameter int P_ADMIT_COMPLIMENT_EN = 1,
  parameter int P_ERR_CNT_W           = 8
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      i_in_vld,
  input  logic [u_cnt_w(P_W)-1:0]   i_in_n,
  input  logic                      i_in_cmpl,
  output logic                      o_in_rdy,
  output logic                      o_out_vld,
  output logic [P_W-1:0]            o_out_x,
  output logic                      o_out_err,
  input  logic                      i_out_rdy,
  input  logic                      i_err_clr,
  output logic [P_ERR_CNT_W-1:0]    o_err_cnt
);

  localparam int                     CNT_W    = u_cnt_w(P_W);
  localparam logic [CNT_W-1:0]       W_MAX    = CNT_W'(P_W);
  localparam logic                   CMPL_EN  = (P_ADMIT_COMPLIMENT_EN != 0);
  localparam logic [P_ERR_CNT_W-1:0] ERR_SAT  = '1;
  localparam logic [1:0]             OCC_FULL = 2'(U_Q_DEPTH);

  typedef struct packed {
    logic           err;
    logic [P_W-1:0] x;
  } entry_t;

  // ---------------------------------------------------------------- encoder
  logic             sat;
  logic [CNT_W-1:0] n_eff;
  logic             cmpl_eff;
  logic             in_err;
  logic [P_W-1:0]   code;
  entry_t           new_entry;

  assign sat      = (i_in_n > W_MAX);
  assign n_eff    = sat ? W_MAX : i_in_n;
  // A refused complement request still produces the plain code, flagged as err.
  assign cmpl_eff = i_in_cmpl & CMPL_EN;
  assign in_err   = sat | (i_in_cmpl & ~CMPL_EN);

  generate
    for (genvar gi = 0; gi < P_W; gi++) begin : g_cell
      u_enc_cell #(
        .P_K     (gi),
        .P_CNT_W (CNT_W)
      ) u_cell (
        .n_eff (n_eff),
        .cmpl  (cmpl_eff),
        .x     (code[gi])
      );
    end
  endgenerate

  assign new_entry.err = in_err;
  assign new_entry.x   = code;

  // ------------------------------------------------------------------ queue
  entry_t     q_reg [U_Q_DEPTH];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] occ_reg;
  logic [1:0] occ_next;
  logic       accept;
  logic       pop;

  // Ready comes only from registered occupancy: no path from i_out_rdy.
  assign o_in_rdy  = (occ_reg != OCC_FULL);
  assign o_out_vld = (occ_reg != 2'd0);
  assign accept    = i_in_vld & o_in_rdy;
  assign pop       = o_out_vld & i_out_rdy;

  always_comb begin
    occ_next = occ_reg;
    case ({accept, pop})
      2'b10:   occ_next = occ_reg + 2'd1;
      2'b01:   occ_next = occ_reg - 2'd1;
      default: occ_next = occ_reg;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      // Storage is cleared too so the head reads as zero after reset.
      for (int i = 0; i < U_Q_DEPTH; i++) begin
        q_reg[i] <= '0;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
    end else begin
      if (accept) begin
        q_reg[wr_ptr_reg] <= new_entry;
        wr_ptr_reg        <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      occ_reg <= occ_next;
    end
  end

  assign o_out_x   = q_reg[rd_ptr_reg].x;
  assign o_out_err = q_reg[rd_ptr_reg].err;

  // ---------------------------------------------------------- error counter
  logic [P_ERR_CNT_W-1:0] err_cnt_reg;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      err_cnt_reg <= '0;
    end else if (i_err_clr) begin
      // Clear wins over a coincident increment.
      err_cnt_reg <= '0;
    end else if (accept && in_err && (err_cnt_reg != ERR_SAT)) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign o_err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_u_enc.sv
// -----------------------------------------------------------------------------
// tb_u_enc: two instances share the same stimulus. dut_a admits complements
// (8-bit error counter); dut_b refuses them (2-bit error counter). A queue-based
// reference model tracks each instance and is compared every cycle.
// -----------------------------------------------------------------------------
module tb_u_enc;

  localparam int W  = 16;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  logic          in_vld  = 1'b0;
  logic [CW-1:0] in_n    = '0;
  logic          in_cmpl = 1'b0;
  logic          out_rdy = 1'b0;
  logic          err_clr = 1'b0;

  logic          rdy_a, vld_a, err_a;
  logic [W-1:0]  x_a;
  logic [7:0]    cnt_a;
  logic          rdy_b, vld_b, err_b;
  logic [W-1:0]  x_b;
  logic [1:0]    cnt_b;

  u_enc #(.P_W(W), .P_ADMIT_COMPLIMENT_EN(1), .P_ERR_CNT_W(8)) dut_a (
    .clk(clk), .arst(arst), .i_in_vld(in_vld), .i_in_n(in_n), .i_in_cmpl(in_cmpl),
    .o_in_rdy(rdy_a), .o_out_vld(vld_a), .o_out_x(x_a), .o_out_err(err_a),
    .i_out_rdy(out_rdy), .i_err_clr(err_clr), .o_err_cnt(cnt_a)
  );

  u_enc #(.P_W(W), .P_ADMIT_COMPLIMENT_EN(0), .P_ERR_CNT_W(2)) dut_b (
    .clk(clk), .arst(arst), .i_in_vld(in_vld), .i_in_n(in_n), .i_in_cmpl(in_cmpl),
    .o_in_rdy(rdy_b), .o_out_vld(vld_b), .o_out_x(x_b), .o_out_err(err_b),
    .i_out_rdy(out_rdy), .i_err_clr(err_clr), .o_err_cnt(cnt_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: {err, x} words in arrival order, plus error counts.
  logic [16:0] qa[$];
  logic [16:0] qb[$];
  int cnt_ma = 0;
  int cnt_mb = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Thermometer word from arithmetic: (2^n_eff - 1), optionally inverted.
  function automatic logic [16:0] ref_word(int n, bit cmpl, bit en);
    int          ne = (n > W) ? W : n;
    logic [31:0] v  = (32'd1 << ne) - 32'd1;
    logic [15:0] x  = v[15:0];
    bit          e;
    if (cmpl && en) x = ~x;
    e = (n > W) || (cmpl && !en);
    return {e, x};
  endfunction

  function automatic bit is_unary(logic [15:0] x);
    return ((x & (x + 16'd1)) == 16'd0);
  endfunction

  task automatic check_all();
    chk("a_rdy", 32'(rdy_a), 32'(qa.size() < 2));
    chk("a_vld", 32'(vld_a), 32'(qa.size() > 0));
    if (qa.size() > 0) begin
      chk("a_x",   32'(x_a),   32'(qa[0][15:0]));
      chk("a_err", 32'(err_a), 32'(qa[0][16]));
    end
    chk("a_cnt", 32'(cnt_a), 32'(cnt_ma));
    chk("b_rdy", 32'(rdy_b), 32'(qb.size() < 2));
    chk("b_vld", 32'(vld_b), 32'(qb.size() > 0));
    if (qb.size() > 0) begin
      chk("b_x",   32'(x_b),   32'(qb[0][15:0]));
      chk("b_err", 32'(err_b), 32'(qb[0][16]));
    end
    chk("b_cnt", 32'(cnt_b), 32'(cnt_mb));
  endtask

  // One clock: drive inputs (just after a falling edge), advance the model at
  // the rising edge, compare at the next falling edge.
  task automatic cycle(input bit v, input int n, input bit c, input bit r, input bit clr);
    bit          acc;
    bit          pop;
    logic [16:0] wa;
    logic [16:0] wb;
    in_vld  = v;
    in_n    = CW'(n);
    in_cmpl = c;
    out_rdy = r;
    err_clr = clr;
    acc = v && (qa.size() < 2);
    pop = r && (qa.size() > 0);
    // Downstream admission check on every error-free word being consumed.
    if (vld_a && r && !err_a)
      chk("a_admit", 32'(is_unary(x_a) || is_unary(~x_a)), 32'd1);
    if (vld_b && r && !err_b)
      chk("b_admit", 32'(is_unary(x_b)), 32'd1);
    wa = ref_word(n, c, 1'b1);
    wb = ref_word(n, c, 1'b0);
    @(posedge clk);
    if (pop) begin
      void'(qa.pop_front());
      void'(qb.pop_front());
    end
    if (acc) begin
      qa.push_back(wa);
      qb.push_back(wb);
    end
    if (clr) begin
      cnt_ma = 0;
      cnt_mb = 0;
    end else if (acc) begin
      if (wa[16] && cnt_ma < 255) cnt_ma++;
      if (wb[16] && cnt_mb < 3)   cnt_mb++;
    end
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    int          n;
    bit          c;
    logic [15:0] xa;
    bit          ea;
    logic [15:0] xb;
    bit          eb;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{0,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[1] = '{5,  1'b0, 16'h001F, 1'b0, 16'h001F, 1'b0};
    tbl[2] = '{16, 1'b0, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0};
    tbl[3] = '{5,  1'b1, 16'hFFE0, 1'b0, 16'h001F, 1'b1};
    tbl[4] = '{17, 1'b0, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tbl[5] = '{17, 1'b1, 16'h0000, 1'b1, 16'hFFFF, 1'b1};

    // Reset state
    #2;
    chk("rst_a_rdy", 32'(rdy_a), 32'd1);
    chk("rst_a_vld", 32'(vld_a), 32'd0);
    chk("rst_a_x",   32'(x_a),   32'd0);
    chk("rst_a_err", 32'(err_a), 32'd0);
    chk("rst_a_cnt", 32'(cnt_a), 32'd0);
    chk("rst_b_vld", 32'(vld_b), 32'd0);
    chk("rst_b_cnt", 32'(cnt_b), 32'd0);
    @(negedge clk);
    arst = 1'b0;

    // Back-to-back table vectors, consumer always ready
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, tbl[i].n, tbl[i].c, 1'b1, 1'b0);
      chk("tbl_a_vld", 32'(vld_a), 32'd1);
      chk("tbl_a_x",   32'(x_a),   32'(tbl[i].xa));
      chk("tbl_a_err", 32'(err_a), 32'(tbl[i].ea));
      chk("tbl_b_x",   32'(x_b),   32'(tbl[i].xb));
      chk("tbl_b_err", 32'(err_b), 32'(tbl[i].eb));
    end
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("tbl_cnt_a", 32'(cnt_a), 32'd2);
    chk("tbl_cnt_b", 32'(cnt_b), 32'd3);

    // Counter saturation and clear priority
    for (int i = 0; i < 6; i++) cycle(1'b1, 17, 1'b0, 1'b1, 1'b0);
    chk("sat_cnt_b", 32'(cnt_b), 32'd3);
    chk("sat_cnt_a", 32'(cnt_a), 32'd8);
    cycle(1'b1, 17, 1'b0, 1'b1, 1'b1);
    chk("clr_cnt_a", 32'(cnt_a), 32'd0);
    chk("clr_cnt_b", 32'(cnt_b), 32'd0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Backpressure: three offers with consumer stalled
    cycle(1'b1, 1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3, 1'b0, 1'b0, 1'b0);
    chk("bp_full_rdy", 32'(rdy_a), 32'd0);
    chk("bp_head",     32'(x_a),   32'h0001);
    cycle(1'b1, 3, 1'b0, 1'b0, 1'b0);
    chk("bp_head_hold", 32'(x_a), 32'h0001);
    cycle(1'b1, 3, 1'b0, 1'b1, 1'b0);
    chk("bp_pop1_rdy", 32'(rdy_a), 32'd1);
    chk("bp_head2",    32'(x_a),   32'h0003);
    cycle(1'b1, 3, 1'b0, 1'b1, 1'b0);
    chk("bp_head3",    32'(x_a),   32'h0007);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("bp_empty",    32'(vld_a), 32'd0);

    // Occupancy 1 with simultaneous accept and pop across pointer wraps
    cycle(1'b1, 4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 5 + i, 1'b0, 1'b1, 1'b0);
      chk("wrap_vld", 32'(vld_a), 32'd1);
      chk("wrap_rdy", 32'(rdy_a), 32'd1);
      chk("wrap_x",   32'(x_a),   (32'd1 << (5 + i)) - 32'd1);
    end
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset with two erroneous words queued
    cycle(1'b1, 20, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 18, 1'b1, 1'b0, 1'b0);
    arst = 1'b1;
    #1;
    chk("arst_a_vld", 32'(vld_a), 32'd0);
    chk("arst_a_rdy", 32'(rdy_a), 32'd1);
    chk("arst_a_cnt", 32'(cnt_a), 32'd0);
    chk("arst_a_x",   32'(x_a),   32'd0);
    chk("arst_b_cnt", 32'(cnt_b), 32'd0);
    qa.delete();
    qb.delete();
    cnt_ma = 0;
    cnt_mb = 0;
    @(negedge clk);
    arst = 1'b0;
    cycle(1'b1, 9, 1'b0, 1'b0, 1'b0);
    chk("post_rst_x", 32'(x_a), 32'h01FF);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
